// File: rtl/alu_operand_issue.sv
// ID/EX operand issue stage: register file, EX/WB forwarding, load-use bubbles
// and the registered a/b/op interface into the ALU.
module alu_operand_issue #(
    parameter int          XLEN       = 32,
    parameter int          NREG       = 32,
    parameter int          LOAD_STALL = 1,
    parameter logic [4:0]  NOP_OP     = 5'b00000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [4:0]      id_op,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic            id_is_load,
    input  logic            flush,
    input  logic            ex_wen,
    input  logic [4:0]      ex_rd_in,
    input  logic            ex_is_load_in,
    input  logic [XLEN-1:0] ex_result,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [4:0]      op,
    output logic [4:0]      ex_rd,
    output logic            ex_load,
    output logic            ex_valid
);

    typedef enum logic {RUN, STALL} state_t;

    state_t          state;
    logic [1:0]      cnt;
    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            hazard;
    logic            bubble;

    // Forwarding priority: r0, then a non-load EX result, then the WB write, then the file.
    always_comb begin
        rs1_val = regs[id_rs1];
        if (id_rs1 == 5'd0)
            rs1_val = '0;
        else if (ex_wen && ex_rd_in == id_rs1 && !ex_is_load_in)
            rs1_val = ex_result;
        else if (wb_en && wb_addr == id_rs1)
            rs1_val = wb_data;

        rs2_val = regs[id_rs2];
        if (id_use_imm)
            rs2_val = id_imm;
        else if (id_rs2 == 5'd0)
            rs2_val = '0;
        else if (ex_wen && ex_rd_in == id_rs2 && !ex_is_load_in)
            rs2_val = ex_result;
        else if (wb_en && wb_addr == id_rs2)
            rs2_val = wb_data;
    end

    assign hazard = id_valid && ex_wen && ex_is_load_in && (ex_rd_in != 5'd0) &&
                    ((ex_rd_in == id_rs1) || ((ex_rd_in == id_rs2) && !id_use_imm));
    assign bubble = flush || (state == STALL) || hazard;
    assign stall  = !rst && !flush && ((state == STALL) || hazard);

    // The hazard-detection cycle is the first bubble, so STALL only covers the
    // remaining LOAD_STALL-1 cycles and cnt holds how many follow the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            cnt      <= '0;
            a        <= '0;
            b        <= '0;
            op       <= NOP_OP;
            ex_rd    <= '0;
            ex_load  <= 1'b0;
            ex_valid <= 1'b0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            if (wb_en && wb_addr != 5'd0)
                regs[wb_addr] <= wb_data;

            if (flush) begin
                state <= RUN;
                cnt   <= '0;
            end else if (state == STALL) begin
                if (cnt == 2'd0)
                    state <= RUN;
                else
                    cnt <= cnt - 2'd1;
            end else if (hazard && LOAD_STALL > 1) begin
                state <= STALL;
                cnt   <= 2'(LOAD_STALL - 2);
            end

            if (bubble) begin
                op       <= NOP_OP;
                ex_rd    <= '0;
                ex_load  <= 1'b0;
                ex_valid <= 1'b0;
            end else begin
                a        <= rs1_val;
                b        <= rs2_val;
                op       <= id_valid ? id_op : NOP_OP;
                ex_rd    <= id_rd;
                ex_load  <= id_is_load;
                ex_valid <= id_valid;
            end
        end
    end

endmodule
